bti_dma: RTL and testbench
==========================

BTI_DMA -- requirements
Module: bti_dma

Interface
- REQ-001 SHALL have parameter BTI_AW, default 32: BTI address width.
- REQ-002 SHALL have parameter BTI_DW, default 32: BTI data width; a word is BTI_DW/8 bytes.
- REQ-003 SHALL have parameter LEN_W, default 16: width of the word-count input.
- REQ-004 SHALL have port clk, input, 1: single clock, all logic rising-edge.
- REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
- REQ-006 SHALL have port start, input, 1: one-cycle transfer launch pulse.
- REQ-007 SHALL have port src_addr, input, BTI_AW: word-aligned source byte address, sampled at start.
- REQ-008 SHALL have port dst_addr, input, BTI_AW: word-aligned destination byte address, sampled at start.
- REQ-009 SHALL have port len, input, LEN_W: number of words to copy, sampled at start.
- REQ-010 SHALL have port busy, output, 1: transfer in progress.
- REQ-011 SHALL have port done, output, 1: one-cycle completion pulse.
- REQ-012 SHALL have port err, output, 1: sticky error flag, cleared by the next accepted start.
- REQ-013 SHALL have port bti_req_mst, bti_req_if_t #(BTI_AW, BTI_DW), initiator side: carries vld, rdy, addr, cmd (read/write), wdata and full strobe.
- REQ-014 SHALL have port bti_rsp_slv, bti_rsp_if_t #(BTI_DW), receiver side: carries vld, rdy, data and ok.

Function
- REQ-015 SHALL implement FSM states IDLE, RD_REQ, RD_RSP, WR_REQ, WR_RSP and FIN.
- REQ-016 SHALL leave IDLE on start: len=0 goes to FIN; otherwise it goes to RD_REQ.
- REQ-017 SHALL ignore start while busy is high.
- REQ-018 SHALL hold req.vld high in RD_REQ with cmd=read and addr=current src, and SHALL move to RD_RSP on the vld&&rdy cycle.
- REQ-019 SHALL, in RD_RSP, hold rsp.rdy=1, capture rsp.data into a data register on rsp.vld, and go to WR_REQ.
- REQ-020 SHALL hold req.vld high in WR_REQ with cmd=write, addr=current dst, wdata=the data register and all strobes set, and SHALL move to WR_RSP on handshake.
- REQ-021 SHALL, on rsp.vld in WR_RSP, add BTI_DW/8 to both src and dst, decrement the remaining count, and go to RD_REQ if the count is non-zero, else to FIN.
- REQ-022 SHALL hold the addr, cmd and wdata request fields stable while req.vld=1 and rdy=0.
- REQ-023 SHALL keep at most one transaction outstanding; rsp.rdy is 0 outside RD_RSP and WR_RSP.
- REQ-024 SHALL, on rsp.vld with ok=0 in any response state, set err, abandon the remaining words and go to FIN.
- REQ-025 SHALL let addresses wrap modulo 2^BTI_AW without an error.
- REQ-026 SHALL pulse done for exactly one cycle in FIN, then return to IDLE.
- REQ-027 SHALL drive busy=1 in every state except IDLE.
- REQ-028 SHALL give a minimum per-word latency of 4 cycles when rdy and rsp.vld are immediate.

Reset
- REQ-029 SHALL, while rst_n=0, put the FSM in IDLE and drive busy=0, done=0, err=0, req.vld=0 and rsp.rdy=0.
- REQ-030 SHALL clear all address, count and data registers to 0 on reset.
- REQ-031 SHALL abort any transfer on reset mid-operation, with no done pulse generated.

Configuration
- REQ-032 SHALL, when BTI_DMA_FILL_EN is defined, add input fill (1) and input fill_data (BTI_DW), both sampled at start.
- REQ-033 SHALL, when BTI_DMA_FILL_EN is defined and fill=1, skip RD_REQ and RD_RSP and write fill_data to len consecutive dst words.
- REQ-034 SHALL, without BTI_DMA_FILL_EN, have neither port and implement copy-only behaviour.

Structure
- REQ-035 SHALL place the BTI cmd enum (BTI_RD, BTI_WR) and the FSM state enum in shared package bti_pkg.
- REQ-036 SHALL be implemented as a single module; no sub-module is required.

Verification
- REQ-037 SHALL cover a plain copy: src=0x0, dst=0x100, len=4 against bti_sram with zero wait states -> dst words equal src words, done asserted once, 16 cycles of busy in the core loop, err=0.
- REQ-038 SHALL cover len=0: start -> done two cycles after start, no req.vld ever asserted.
- REQ-039 SHALL cover backpressure: rdy held 0 for 5 cycles on the second read -> addr, cmd and wdata stable throughout, copy correct.
- REQ-040 SHALL cover an error response: ok=0 on the 2nd write with len=4 -> err=1, done pulse, only word 0 written, busy=0 afterwards.
- REQ-041 SHALL cover reset and start-while-busy: rst_n pulsed low mid-transfer -> outputs at reset values, no done; start asserted while busy -> ignored and the sampled parameters unchanged.
- REQ-042 SHALL cover fill mode when BTI_DMA_FILL_EN is defined: fill=1, fill_data=0xDEADBEEF, dst=0x40, len=3 -> three writes of 0xDEADBEEF to 0x40, 0x44 and 0x48, and no reads.

Source files
------------

// File: rtl/bti_pkg.sv
// Shared BTI command encoding and DMA controller state encoding.
package bti_pkg;

    typedef enum logic {
        BTI_RD = 1'b0,
        BTI_WR = 1'b1
    } bti_cmd_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_REQ = 3'd1,
        RD_RSP = 3'd2,
        WR_REQ = 3'd3,
        WR_RSP = 3'd4,
        FIN    = 3'd5
    } dma_state_e;

endpackage

// File: rtl/bti_if.sv
// BTI request channel (initiator drives payload) and response channel (target drives payload).
interface bti_req_if_t #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic                 vld;
    logic                 rdy;
    logic [AW-1:0]        addr;
    bti_pkg::bti_cmd_e    cmd;
    logic [DW-1:0]        wdata;
    logic [DW/8-1:0]      strb;

    modport mst (output vld, addr, cmd, wdata, strb, input rdy);
    modport slv (input vld, addr, cmd, wdata, strb, output rdy);
endinterface

interface bti_rsp_if_t #(
    parameter int unsigned DW = 32
);
    logic          vld;
    logic          rdy;
    logic [DW-1:0] data;
    logic          ok;

    modport mst (output vld, data, ok, input rdy);
    modport slv (input vld, data, ok, output rdy);
endinterface

// File: rtl/bti_dma.sv
// Word-by-word BTI memory-to-memory copy engine, one transaction outstanding at a time.
// Defining BTI_DMA_FILL_EN adds a fill mode that writes a constant pattern without reading.
module bti_dma
    import bti_pkg::*;
#(
    parameter int unsigned BTI_AW = 32,
    parameter int unsigned BTI_DW = 32,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [BTI_AW-1:0] src_addr,
    input  logic [BTI_AW-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
`ifdef BTI_DMA_FILL_EN
    input  logic              fill,
    input  logic [BTI_DW-1:0] fill_data,
`endif
    output logic              busy,
    output logic              done,
    output logic              err,
    bti_req_if_t.mst          bti_req_mst,
    bti_rsp_if_t.slv          bti_rsp_slv
);

    localparam int unsigned       WORD_BYTES = BTI_DW / 8;
    localparam logic [BTI_AW-1:0] ADDR_STEP  = BTI_AW'(WORD_BYTES);

    dma_state_e        r_state;
    logic [BTI_AW-1:0] r_src;
    logic [BTI_AW-1:0] r_dst;
    logic [LEN_W-1:0]  r_cnt;
    logic [BTI_DW-1:0] r_data;
    logic              r_fill;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_req_vld;
    bti_cmd_e          r_req_cmd;
    logic [BTI_AW-1:0] r_req_addr;
    logic              r_rsp_rdy;

    logic              w_req_hs;
    logic              w_rsp_hs;
    logic              w_last;
    logic              w_fill;
    logic [BTI_DW-1:0] w_fill_data;
    logic [BTI_AW-1:0] w_src_nxt;
    logic [BTI_AW-1:0] w_dst_nxt;

`ifdef BTI_DMA_FILL_EN
    assign w_fill      = fill;
    assign w_fill_data = fill_data;
`else
    assign w_fill      = 1'b0;
    assign w_fill_data = '0;
`endif

    assign w_req_hs  = r_req_vld & bti_req_mst.rdy;
    assign w_rsp_hs  = r_rsp_rdy & bti_rsp_slv.vld;
    assign w_last    = (r_cnt == LEN_W'(1));
    assign w_src_nxt = r_src + ADDR_STEP;
    assign w_dst_nxt = r_dst + ADDR_STEP;

    // Sequencer: every output and request field is a register updated on state transitions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_src      <= '0;
            r_dst      <= '0;
            r_cnt      <= '0;
            r_data     <= '0;
            r_fill     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_req_vld  <= 1'b0;
            r_req_cmd  <= BTI_RD;
            r_req_addr <= '0;
            r_rsp_rdy  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_src  <= src_addr;
                        r_dst  <= dst_addr;
                        r_cnt  <= len;
                        r_fill <= w_fill;
                        r_err  <= 1'b0;
                        r_busy <= 1'b1;
                        if (w_fill) begin
                            r_data <= w_fill_data;
                        end
                        if (len == '0) begin
                            r_state <= FIN;
                        end else if (w_fill) begin
                            r_state    <= WR_REQ;
                            r_req_vld  <= 1'b1;
                            r_req_cmd  <= BTI_WR;
                            r_req_addr <= dst_addr;
                        end else begin
                            r_state    <= RD_REQ;
                            r_req_vld  <= 1'b1;
                            r_req_cmd  <= BTI_RD;
                            r_req_addr <= src_addr;
                        end
                    end
                end
                RD_REQ: begin
                    if (w_req_hs) begin
                        r_req_vld <= 1'b0;
                        r_rsp_rdy <= 1'b1;
                        r_state   <= RD_RSP;
                    end
                end
                RD_RSP: begin
                    if (w_rsp_hs) begin
                        r_rsp_rdy <= 1'b0;
                        if (!bti_rsp_slv.ok) begin
                            r_err   <= 1'b1;
                            r_state <= FIN;
                        end else begin
                            r_data     <= bti_rsp_slv.data;
                            r_state    <= WR_REQ;
                            r_req_vld  <= 1'b1;
                            r_req_cmd  <= BTI_WR;
                            r_req_addr <= r_dst;
                        end
                    end
                end
                WR_REQ: begin
                    if (w_req_hs) begin
                        r_req_vld <= 1'b0;
                        r_rsp_rdy <= 1'b1;
                        r_state   <= WR_RSP;
                    end
                end
                WR_RSP: begin
                    if (w_rsp_hs) begin
                        r_rsp_rdy <= 1'b0;
                        if (!bti_rsp_slv.ok) begin
                            r_err   <= 1'b1;
                            r_state <= FIN;
                        end else begin
                            r_src <= w_src_nxt;
                            r_dst <= w_dst_nxt;
                            r_cnt <= r_cnt - LEN_W'(1);
                            if (w_last) begin
                                r_state <= FIN;
                            end else if (r_fill) begin
                                r_state    <= WR_REQ;
                                r_req_vld  <= 1'b1;
                                r_req_cmd  <= BTI_WR;
                                r_req_addr <= w_dst_nxt;
                            end else begin
                                r_state    <= RD_REQ;
                                r_req_vld  <= 1'b1;
                                r_req_cmd  <= BTI_RD;
                                r_req_addr <= w_src_nxt;
                            end
                        end
                    end
                end
                FIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign err   = r_err;

    assign bti_req_mst.vld   = r_req_vld;
    assign bti_req_mst.cmd   = r_req_cmd;
    assign bti_req_mst.addr  = r_req_addr;
    assign bti_req_mst.wdata = r_data;
    assign bti_req_mst.strb  = '1;
    assign bti_rsp_slv.rdy   = r_rsp_rdy;

endmodule

// File: tb/tb_bti_dma.sv
// Self-checking bench for bti_dma: behavioural SRAM target plus a word-sequential reference copy model.
module tb_bti_dma;
    import bti_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 16;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          start    = 1'b0;
    logic [31:0]   src_addr = '0;
    logic [31:0]   dst_addr = '0;
    logic [15:0]   len      = '0;
`ifdef BTI_DMA_FILL_EN
    logic          fill      = 1'b0;
    logic [31:0]   fill_data = '0;
`endif
    logic          busy;
    logic          done;
    logic          err;

    bti_req_if_t #(.AW(AW), .DW(DW)) req_if ();
    bti_rsp_if_t #(.DW(DW))          rsp_if ();

    bti_dma #(.BTI_AW(AW), .BTI_DW(DW), .LEN_W(LW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .src_addr    (src_addr),
        .dst_addr    (dst_addr),
        .len         (len),
`ifdef BTI_DMA_FILL_EN
        .fill        (fill),
        .fill_data   (fill_data),
`endif
        .busy        (busy),
        .done        (done),
        .err         (err),
        .bti_req_mst (req_if),
        .bti_rsp_slv (rsp_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- behavioural SRAM target (1 KiB window, addr[9:2]) ----------------
    logic [31:0] mem  [256];
    logic [31:0] refm [256];
    int          rd_total    = 0;
    int          wr_total    = 0;
    int          stall_run   = 0;
    int          strb_bad    = 0;
    int          stall_rd_at = -1;
    int          fail_wr_at  = -1;
    logic        s_vld;
    logic        s_ok;
    logic [31:0] s_data;
    bit          log_wr   [$];
    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];

    assign req_if.rdy  = !(req_if.vld && req_if.cmd == BTI_RD && rd_total == stall_rd_at && stall_run < 5);
    assign rsp_if.vld  = s_vld;
    assign rsp_if.data = s_data;
    assign rsp_if.ok   = s_ok;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_vld     <= 1'b0;
            s_ok      <= 1'b0;
            s_data    <= '0;
            stall_run <= 0;
            for (int i = 0; i < 256; i++) mem[i] <= $urandom;
        end else begin
            if (s_vld && rsp_if.rdy) s_vld <= 1'b0;
            if (req_if.vld && !req_if.rdy) stall_run <= stall_run + 1;
            if (req_if.vld && req_if.rdy) begin
                stall_run <= 0;
                log_wr.push_back(req_if.cmd == BTI_WR);
                log_addr.push_back(req_if.addr);
                log_data.push_back(req_if.wdata);
                s_vld <= 1'b1;
                if (req_if.cmd == BTI_RD) begin
                    s_data   <= mem[req_if.addr[9:2]];
                    s_ok     <= 1'b1;
                    rd_total <= rd_total + 1;
                end else begin
                    s_data <= '0;
                    s_ok   <= (wr_total != fail_wr_at);
                    if (wr_total != fail_wr_at) mem[req_if.addr[9:2]] <= req_if.wdata;
                    if (req_if.strb !== 4'hF) strb_bad <= strb_bad + 1;
                    wr_total <= wr_total + 1;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    bit          exp_wr   [$];
    logic [31:0] exp_addr [$];
    logic [31:0] exp_data [$];

    task automatic snap();
        for (int i = 0; i < 256; i++) refm[i] = mem[i];
    endtask

    // Copy (or fill) word by word; write number fail_k (1-based) is rejected and ends the job.
    function automatic void model_xfer(input logic [31:0] s, input logic [31:0] d, input int n,
                                       input bit f, input logic [31:0] fd, input int fail_k);
        logic [31:0] sa;
        logic [31:0] da;
        logic [31:0] v;
        exp_wr.delete(); exp_addr.delete(); exp_data.delete();
        for (int i = 0; i < n; i++) begin
            sa = s + 32'(4 * i);
            da = d + 32'(4 * i);
            if (f) begin
                v = fd;
            end else begin
                v = refm[sa[9:2]];
                exp_wr.push_back(1'b0); exp_addr.push_back(sa); exp_data.push_back('0);
            end
            exp_wr.push_back(1'b1); exp_addr.push_back(da); exp_data.push_back(v);
            if (i + 1 == fail_k) return;
            refm[da[9:2]] = v;
        end
    endfunction

    function automatic int log_diff(input int base);
        int bad;
        int got;
        bad = 0;
        got = log_wr.size() - base;
        if (got != exp_wr.size()) bad += 100;
        for (int i = 0; i < exp_wr.size(); i++) begin
            if (base + i >= log_wr.size()) bad++;
            else if (log_wr[base+i] !== exp_wr[i] || log_addr[base+i] !== exp_addr[i] ||
                     (exp_wr[i] && log_data[base+i] !== exp_data[i])) bad++;
        end
        return bad;
    endfunction

    function automatic int mem_diff();
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== refm[i]) bad++;
        return bad;
    endfunction

    // ---------------- stimulus driver / measurement ----------------
    int x_lat, x_busy, x_vld, x_done, x_stall, x_stall_bad;
    bit x_to;

    task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input int n, input int budget);
        logic [31:0] sa;
        logic [31:0] sw;
        bit          sc;
        bit          in_stall;
        sa = '0; sw = '0; sc = 1'b0; in_stall = 1'b0;
        x_lat = 0; x_busy = 0; x_vld = 0; x_done = 0; x_stall = 0; x_stall_bad = 0; x_to = 1'b1;
        @(negedge clk);
        src_addr = s; dst_addr = d; len = 16'(n); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            if (busy) x_busy++;
            if (req_if.vld) x_vld++;
            if (req_if.vld && !req_if.rdy) begin
                x_stall++;
                if (in_stall && (req_if.addr !== sa || (req_if.cmd == BTI_WR) !== sc || req_if.wdata !== sw))
                    x_stall_bad++;
                sa = req_if.addr; sc = (req_if.cmd == BTI_WR); sw = req_if.wdata; in_stall = 1'b1;
            end else begin
                in_stall = 1'b0;
            end
            if (done) begin
                x_lat = c; x_to = 1'b0; x_done++;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        if (done) x_done++;
    endtask

    function automatic logic [31:0] rnd_addr(input int word_idx);
        logic [31:0] hi;
        hi = $urandom;
        return {hi[31:10], 8'(word_idx), 2'b00};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0)       begin n_errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0)       begin n_errors++; $display("FAIL rst_done: got %b want 0", done); end
        n_checks++; if (err !== 1'b0)        begin n_errors++; $display("FAIL rst_err: got %b want 0", err); end
        n_checks++; if (req_if.vld !== 1'b0) begin n_errors++; $display("FAIL rst_req_vld: got %b want 0", req_if.vld); end
        n_checks++; if (rsp_if.rdy !== 1'b0) begin n_errors++; $display("FAIL rst_rsp_rdy: got %b want 0", rsp_if.rdy); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0 || req_if.vld !== 1'b0) begin
            n_errors++; $display("FAIL idle_after_rst: busy=%b vld=%b want 0 0", busy, req_if.vld);
        end
    endtask

    task automatic test_copy();
        for (int k = 0; k < 4; k++) begin
            logic [31:0] s;
            logic [31:0] d;
            int          n;
            int          base;
            int          sb0;
            if (k == 0) begin
                s = 32'h0; d = 32'h100; n = 4;
            end else begin
                s = rnd_addr($urandom_range(0, 100));
                d = rnd_addr(128 + $urandom_range(0, 100));
                n = $urandom_range(1, 20);
            end
            snap();
            model_xfer(s, d, n, 1'b0, '0, 0);
            base = log_wr.size();
            sb0  = strb_bad;
            run_xfer(s, d, n, 200);
            n_checks++; if (x_to !== 1'b0) begin n_errors++; $display("FAIL copy_timeout[%0d]: done not seen, want done", k); end
            n_checks++; if (x_lat !== 4*n+2) begin n_errors++; $display("FAIL copy_latency[%0d]: got %0d want %0d", k, x_lat, 4*n+2); end
            n_checks++; if (x_busy !== 4*n+1) begin n_errors++; $display("FAIL copy_busy_cycles[%0d]: got %0d want %0d", k, x_busy, 4*n+1); end
            n_checks++; if (x_done !== 1) begin n_errors++; $display("FAIL copy_done_pulse[%0d]: got %0d cycles want 1", k, x_done); end
            n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL copy_err[%0d]: got %b want 0", k, err); end
            n_checks++; if (log_diff(base) !== 0) begin n_errors++; $display("FAIL copy_bus_trace[%0d]: %0d bad entries want 0", k, log_diff(base)); end
            n_checks++; if (mem_diff() !== 0) begin n_errors++; $display("FAIL copy_memory[%0d]: %0d bad words want 0", k, mem_diff()); end
            n_checks++; if (strb_bad !== sb0) begin n_errors++; $display("FAIL copy_strobe[%0d]: %0d partial strobes want 0", k, strb_bad - sb0); end
        end
    endtask

    task automatic test_len0();
        int base;
        snap();
        model_xfer(rnd_addr(3), rnd_addr(200), 0, 1'b0, '0, 0);
        base = log_wr.size();
        run_xfer(rnd_addr(3), rnd_addr(200), 0, 20);
        n_checks++; if (x_to !== 1'b0) begin n_errors++; $display("FAIL len0_timeout: done not seen, want done"); end
        n_checks++; if (x_lat !== 2) begin n_errors++; $display("FAIL len0_latency: got %0d want 2", x_lat); end
        n_checks++; if (x_vld !== 0) begin n_errors++; $display("FAIL len0_req_vld: got %0d cycles want 0", x_vld); end
        n_checks++; if (log_diff(base) !== 0) begin n_errors++; $display("FAIL len0_bus_trace: %0d bad want 0", log_diff(base)); end
        n_checks++; if (x_done !== 1) begin n_errors++; $display("FAIL len0_done_pulse: got %0d want 1", x_done); end
    endtask

    task automatic test_wrap();
        int base;
        snap();
        model_xfer(32'hFFFF_FFF8, 32'h0000_0200, 4, 1'b0, '0, 0);
        base = log_wr.size();
        run_xfer(32'hFFFF_FFF8, 32'h0000_0200, 4, 100);
        n_checks++; if (x_to !== 1'b0 || err !== 1'b0) begin n_errors++; $display("FAIL wrap_status: to=%b err=%b want 0 0", x_to, err); end
        n_checks++; if (log_diff(base) !== 0) begin n_errors++; $display("FAIL wrap_bus_trace: %0d bad want 0", log_diff(base)); end
        n_checks++; if (mem_diff() !== 0) begin n_errors++; $display("FAIL wrap_memory: %0d bad words want 0", mem_diff()); end
    endtask

    task automatic test_backpressure();
        logic [31:0] s;
        logic [31:0] d;
        int          base;
        s = rnd_addr($urandom_range(0, 100));
        d = rnd_addr(128 + $urandom_range(0, 100));
        snap();
        model_xfer(s, d, 4, 1'b0, '0, 0);
        base = log_wr.size();
        stall_rd_at = rd_total + 1;
        run_xfer(s, d, 4, 200);
        stall_rd_at = -1;
        n_checks++; if (x_stall !== 5) begin n_errors++; $display("FAIL bp_stall_cycles: got %0d want 5", x_stall); end
        n_checks++; if (x_stall_bad !== 0) begin n_errors++; $display("FAIL bp_fields_stable: %0d changes want 0", x_stall_bad); end
        n_checks++; if (x_lat !== 23) begin n_errors++; $display("FAIL bp_latency: got %0d want 23", x_lat); end
        n_checks++; if (log_diff(base) !== 0) begin n_errors++; $display("FAIL bp_bus_trace: %0d bad want 0", log_diff(base)); end
        n_checks++; if (mem_diff() !== 0) begin n_errors++; $display("FAIL bp_memory: %0d bad words want 0", mem_diff()); end
    endtask

    task automatic test_error();
        logic [31:0] s;
        logic [31:0] d;
        int          base;
        s = rnd_addr($urandom_range(0, 100));
        d = rnd_addr(128 + $urandom_range(0, 100));
        snap();
        model_xfer(s, d, 4, 1'b0, '0, 2);
        base = log_wr.size();
        fail_wr_at = wr_total + 1;
        run_xfer(s, d, 4, 200);
        fail_wr_at = -1;
        n_checks++; if (x_to !== 1'b0) begin n_errors++; $display("FAIL err_timeout: done not seen, want done"); end
        n_checks++; if (x_lat !== 10) begin n_errors++; $display("FAIL err_latency: got %0d want 10", x_lat); end
        n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL err_flag: got %b want 1", err); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL err_busy_after: got %b want 0", busy); end
        n_checks++; if (log_diff(base) !== 0) begin n_errors++; $display("FAIL err_bus_trace: %0d bad want 0", log_diff(base)); end
        n_checks++; if (mem_diff() !== 0) begin n_errors++; $display("FAIL err_memory: %0d bad words want 0", mem_diff()); end
        repeat (3) @(negedge clk);
        n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL err_sticky: got %b want 1", err); end
        snap();
        model_xfer(s, d, 1, 1'b0, '0, 0);
        run_xfer(s, d, 1, 50);
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL err_cleared_by_start: got %b want 0", err); end
    endtask

    task automatic test_reset_mid();
        int dseen;
        int bseen;
        @(negedge clk);
        src_addr = rnd_addr(5); dst_addr = rnd_addr(150); len = 16'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL mid_busy_before_rst: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        n_checks++; if ({busy, done, err, req_if.vld, rsp_if.rdy} !== 5'b0) begin
            n_errors++; $display("FAIL mid_rst_outputs: busy/done/err/vld/rdy=%b want 00000",
                                 {busy, done, err, req_if.vld, rsp_if.rdy});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dseen = 0; bseen = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done) dseen++;
            if (busy) bseen++;
        end
        n_checks++; if (dseen !== 0) begin n_errors++; $display("FAIL mid_rst_no_done: got %0d pulses want 0", dseen); end
        n_checks++; if (bseen !== 0) begin n_errors++; $display("FAIL mid_rst_stays_idle: got %0d busy cycles want 0", bseen); end
    endtask

    task automatic test_start_busy();
        logic [31:0] sa;
        logic [31:0] da;
        int          base;
        int          lat;
        sa = rnd_addr($urandom_range(0, 60));
        da = rnd_addr(128 + $urandom_range(0, 60));
        snap();
        model_xfer(sa, da, 3, 1'b0, '0, 0);
        base = log_wr.size();
        lat  = 0;
        @(negedge clk);
        src_addr = sa; dst_addr = da; len = 16'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            if (done) begin
                lat = c;
                break;
            end
            if (c == 3) begin
                src_addr = rnd_addr(70); dst_addr = rnd_addr(250); len = 16'd5; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        n_checks++; if (lat !== 14) begin n_errors++; $display("FAIL sb_latency: got %0d want 14", lat); end
        n_checks++; if (log_diff(base) !== 0) begin n_errors++; $display("FAIL sb_bus_trace: %0d bad want 0", log_diff(base)); end
        n_checks++; if (mem_diff() !== 0) begin n_errors++; $display("FAIL sb_memory: %0d bad words want 0", mem_diff()); end
        repeat (5) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL sb_no_relaunch: busy=%b want 0", busy); end
    endtask

`ifdef BTI_DMA_FILL_EN
    task automatic test_fill();
        int base;
        int rd0;
        snap();
        model_xfer(rnd_addr(9), 32'h40, 3, 1'b1, 32'hDEAD_BEEF, 0);
        base = log_wr.size();
        rd0  = rd_total;
        fill = 1'b1; fill_data = 32'hDEAD_BEEF;
        run_xfer(rnd_addr(9), 32'h40, 3, 100);
        fill = 1'b0; fill_data = '0;
        n_checks++; if (x_lat !== 8) begin n_errors++; $display("FAIL fill_latency: got %0d want 8", x_lat); end
        n_checks++; if (log_diff(base) !== 0) begin n_errors++; $display("FAIL fill_bus_trace: %0d bad want 0", log_diff(base)); end
        n_checks++; if (rd_total !== rd0) begin n_errors++; $display("FAIL fill_no_reads: got %0d reads want 0", rd_total - rd0); end
        n_checks++; if (mem_diff() !== 0) begin n_errors++; $display("FAIL fill_memory: %0d bad words want 0", mem_diff()); end
    endtask
`endif

    initial begin
        test_reset();
        test_copy();
        test_len0();
        test_wrap();
        test_backpressure();
        test_error();
        test_reset_mid();
        test_start_busy();
`ifdef BTI_DMA_FILL_EN
        test_fill();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
